// File: rtl/log_ram_sequencer.sv
// Write-side controller for the circular log RAM: round-robin source arbiter,
// zero-fill clear and freeze/drain. Optional timestamp words via LOG_TIMESTAMP_EN.
module log_ram_sequencer #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_SRC  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      freeze,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ready,
  output logic [ADDR_W-1:0]         ram_address,
  output logic                      ram_chipselect,
  output logic                      ram_write,
  output logic [DATA_W/8-1:0]       ram_byteenable,
  output logic [DATA_W-1:0]         ram_writedata,
  output logic [ADDR_W-1:0]         wr_ptr,
  output logic                      wrapped,
  output logic [15:0]               drop_count,
  output logic                      busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned GNT_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNT_W = $clog2(N_SRC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, RUN, FROZEN, CLEAR} state_t;

  state_t              state, nxt_state;
  logic [GNT_W-1:0]    last_grant, nxt_last_grant;
  logic [ADDR_W-1:0]   clr_cnt, nxt_clr_cnt;
  logic [ADDR_W-1:0]   nxt_addr, nxt_wr_ptr;
  logic [DATA_W-1:0]   nxt_wdata;
  logic                nxt_we, nxt_wrapped, nxt_busy;
  logic [15:0]         nxt_drop, drop_sat;
  logic [16:0]         drop_sum;
  logic [CNT_W-1:0]    drop_inc;
  logic                grant_vld, xfer, ts_hold;
  logic [GNT_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   grant_data;

`ifdef LOG_TIMESTAMP_EN
  logic [15:0]         ts_cnt;
  logic                ts_pend, nxt_ts_pend;
  logic [DATA_W-1:0]   ts_data, nxt_ts_data;
  assign ts_hold = ts_pend;
`else
  assign ts_hold = 1'b0;
`endif

  // Round-robin search starting one past the last granted source
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      if (!grant_vld && src_valid[GNT_W'((32'(last_grant) + k) % N_SRC)]) begin
        grant_vld = 1'b1;
        grant_idx = GNT_W'((32'(last_grant) + k) % N_SRC);
      end
    end
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_idx == GNT_W'(i)) grant_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    src_ready = '0;
    case (state)
      RUN: begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
          src_ready[i] = grant_vld && !ts_hold && (grant_idx == GNT_W'(i));
        end
      end
      FROZEN:  src_ready = src_valid;
      default: src_ready = '0;
    endcase
  end

  assign xfer = (state == RUN) && grant_vld && !ts_hold;

  // Saturating drop accumulator
  always_comb begin
    drop_inc = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      drop_inc = drop_inc + CNT_W'(src_valid[i] & src_ready[i]);
    end
    drop_sum = 17'(drop_count) + 17'(drop_inc);
    drop_sat = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    nxt_state      = state;
    nxt_last_grant = last_grant;
    nxt_clr_cnt    = '0;
    nxt_wr_ptr     = wr_ptr;
    nxt_wrapped    = wrapped;
    nxt_drop       = drop_count;
    nxt_we         = 1'b0;
    nxt_addr       = ram_address;
    nxt_wdata      = ram_writedata;
`ifdef LOG_TIMESTAMP_EN
    nxt_ts_pend    = 1'b0;
    nxt_ts_data    = ts_data;
    // Second word of a timestamped transfer completes whatever the state
    if (ts_pend) begin
      nxt_we     = 1'b1;
      nxt_addr   = wr_ptr;
      nxt_wdata  = ts_data;
      nxt_wr_ptr = wr_ptr + ADDR_W'(1);
      if (wr_ptr == LAST_ADDR) nxt_wrapped = 1'b1;
    end
`endif
    case (state)
      IDLE: begin
        if (clear)       nxt_state = CLEAR;
        else if (freeze) nxt_state = FROZEN;
        else if (enable) nxt_state = RUN;
      end
      RUN: begin
        if (xfer) begin
          nxt_we         = 1'b1;
          nxt_addr       = wr_ptr;
          nxt_wr_ptr     = wr_ptr + ADDR_W'(1);
          nxt_last_grant = grant_idx;
          if (wr_ptr == LAST_ADDR) nxt_wrapped = 1'b1;
`ifdef LOG_TIMESTAMP_EN
          nxt_wdata      = DATA_W'(ts_cnt);
          nxt_ts_pend    = 1'b1;
          nxt_ts_data    = grant_data;
`else
          nxt_wdata      = grant_data;
`endif
        end
        if (clear)        nxt_state = CLEAR;
        else if (freeze)  nxt_state = FROZEN;
        else if (!enable) nxt_state = IDLE;
      end
      FROZEN: begin
        nxt_drop = drop_sat;
        if (clear)        nxt_state = CLEAR;
        else if (!freeze) nxt_state = enable ? RUN : IDLE;
      end
      CLEAR: begin
        nxt_clr_cnt = clr_cnt;
        if (!ts_hold) begin
          nxt_we      = 1'b1;
          nxt_addr    = clr_cnt;
          nxt_wdata   = '0;
          nxt_clr_cnt = clr_cnt + ADDR_W'(1);
          if (!clear && clr_cnt == LAST_ADDR) begin
            nxt_wr_ptr  = '0;
            nxt_wrapped = 1'b0;
            nxt_drop    = '0;
            if (freeze)      nxt_state = FROZEN;
            else if (enable) nxt_state = RUN;
            else             nxt_state = IDLE;
          end
        end
        if (clear) nxt_clr_cnt = '0;
      end
      default: nxt_state = IDLE;
    endcase
    nxt_busy = (nxt_state == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= GNT_W'(N_SRC - 1);
      clr_cnt        <= '0;
      wr_ptr         <= '0;
      wrapped        <= 1'b0;
      drop_count     <= '0;
      busy           <= 1'b0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_byteenable <= '0;
      ram_writedata  <= '0;
`ifdef LOG_TIMESTAMP_EN
      ts_cnt         <= '0;
      ts_pend        <= 1'b0;
      ts_data        <= '0;
`endif
    end else begin
      state          <= nxt_state;
      last_grant     <= nxt_last_grant;
      clr_cnt        <= nxt_clr_cnt;
      wr_ptr         <= nxt_wr_ptr;
      wrapped        <= nxt_wrapped;
      drop_count     <= nxt_drop;
      busy           <= nxt_busy;
      ram_address    <= nxt_addr;
      ram_chipselect <= nxt_we;
      ram_write      <= nxt_we;
      ram_byteenable <= {BE_W{nxt_we}};
      ram_writedata  <= nxt_wdata;
`ifdef LOG_TIMESTAMP_EN
      ts_cnt         <= ts_cnt + 16'd1;
      ts_pend        <= nxt_ts_pend;
      ts_data        <= nxt_ts_data;
`endif
    end
  end

endmodule

// File: tb/tb_log_ram_sequencer.sv
// Self-checking bench for log_ram_sequencer: vector table, corner sequences
// (wrap, freeze saturation, clear restart) and a random run against a queue-free model.
module tb_log_ram_sequencer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int N      = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                  clk, reset_n, enable, clear, freeze;
  logic [N-1:0]          src_valid, src_ready;
  logic [N*DATA_W-1:0]   src_data;
  logic [ADDR_W-1:0]     ram_address, wr_ptr;
  logic                  ram_chipselect, ram_write, wrapped, busy;
  logic [DATA_W/8-1:0]   ram_byteenable;
  logic [DATA_W-1:0]     ram_writedata;
  logic [15:0]           drop_count;

  int tests  = 0;
  int failed = 0;

  log_ram_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SRC(N)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .freeze(freeze),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
    .wr_ptr(wr_ptr), .wrapped(wrapped), .drop_count(drop_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    freeze    = 1'b0;
    src_valid = '1;
    src_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   32'(src_ready), 32'h0);
    chk("rst_addr",    32'(ram_address), 32'h0);
    chk("rst_write",   32'({ram_chipselect, ram_write}), 32'h0);
    chk("rst_be_data", 32'({ram_byteenable, ram_writedata}), 32'h0);
    chk("rst_ptr",     32'(wr_ptr), 32'h0);
    chk("rst_flags",   32'({wrapped, busy}), 32'h0);
    chk("rst_drop",    32'(drop_count), 32'h0);
    @(negedge clk);
    src_valid = '0;
    reset_n   = 1'b1;
  endtask

`ifdef LOG_TIMESTAMP_EN
  task automatic ts_test();
    enable = 1'b1;
    repeat (16) begin
      @(posedge clk);
      @(negedge clk);
    end
    src_valid = 4'b0001;
    src_data[15:0] = 16'hBEEF;
    #1;
    chk("ts_ready", 32'(src_ready), 32'h1);
    @(posedge clk); #1;
    chk("ts_w0_write", 32'(ram_write), 32'h1);
    chk("ts_w0_addr",  32'(ram_address), 32'h0);
    chk("ts_w0_data",  32'(ram_writedata), 32'h0010);
    chk("ts_w0_ptr",   32'(wr_ptr), 32'h1);
    @(negedge clk); #1;
    chk("ts_ready_low", 32'(src_ready), 32'h0);
    @(posedge clk); #1;
    chk("ts_w1_write", 32'(ram_write), 32'h1);
    chk("ts_w1_addr",  32'(ram_address), 32'h1);
    chk("ts_w1_data",  32'(ram_writedata), 32'hBEEF);
    chk("ts_w1_ptr",   32'(wr_ptr), 32'h2);
    @(negedge clk);
    src_valid = '0;
  endtask
`else
  typedef struct {
    logic              en;
    logic [N-1:0]      vld;
    logic [N-1:0]      rdy;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ptr;
  } vec_t;

  task automatic hand_a5();
    enable = 1'b1;
    src_valid = 4'b0001;
    src_data[15:0] = 16'hA5A5;
    @(posedge clk); @(negedge clk); #1;
    chk("a5_ready", 32'(src_ready), 32'h1);
    @(posedge clk); #1;
    chk("a5_cs_write", 32'({ram_chipselect, ram_write}), 32'h3);
    chk("a5_addr",     32'(ram_address), 32'h0);
    chk("a5_data",     32'(ram_writedata), 32'hA5A5);
    chk("a5_be",       32'(ram_byteenable), 32'h3);
    chk("a5_ptr",      32'(wr_ptr), 32'h1);
    @(negedge clk);
    src_valid = '0;
    @(posedge clk); #1;
    chk("a5_write_drop", 32'({ram_chipselect, ram_write}), 32'h0);
    @(negedge clk);
  endtask

  task automatic table_test();
    vec_t vt[15];
    int   rcnt[N];
    vt[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 14'd0,  16'h0000, 14'd0};
    vt[1]  = '{1'b1, 4'b1111, 4'b0001, 1'b1, 14'd0,  16'hA0A0, 14'd1};
    vt[2]  = '{1'b1, 4'b1111, 4'b0010, 1'b1, 14'd1,  16'hB1B1, 14'd2};
    vt[3]  = '{1'b1, 4'b1111, 4'b0100, 1'b1, 14'd2,  16'hC2C2, 14'd3};
    vt[4]  = '{1'b1, 4'b1111, 4'b1000, 1'b1, 14'd3,  16'hD3D3, 14'd4};
    vt[5]  = '{1'b1, 4'b1111, 4'b0001, 1'b1, 14'd4,  16'hA0A0, 14'd5};
    vt[6]  = '{1'b1, 4'b1111, 4'b0010, 1'b1, 14'd5,  16'hB1B1, 14'd6};
    vt[7]  = '{1'b1, 4'b1111, 4'b0100, 1'b1, 14'd6,  16'hC2C2, 14'd7};
    vt[8]  = '{1'b1, 4'b1111, 4'b1000, 1'b1, 14'd7,  16'hD3D3, 14'd8};
    vt[9]  = '{1'b1, 4'b1010, 4'b0010, 1'b1, 14'd8,  16'hB1B1, 14'd9};
    vt[10] = '{1'b1, 4'b0011, 4'b0001, 1'b1, 14'd9,  16'hA0A0, 14'd10};
    vt[11] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 14'd10, 16'hD3D3, 14'd11};
    vt[12] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 14'd11, 16'hC2C2, 14'd12};
    vt[13] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 14'd0,  16'h0000, 14'd12};
    vt[14] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 14'd0,  16'h0000, 14'd12};
    for (int i = 0; i < N; i++) rcnt[i] = 0;
    do_reset();
    src_data = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    for (int r = 0; r < 15; r++) begin
      enable    = vt[r].en;
      src_valid = vt[r].vld;
      #1;
      chk($sformatf("vec%0d_ready", r), 32'(src_ready), 32'(vt[r].rdy));
      if (r >= 1 && r <= 8) for (int i = 0; i < N; i++) rcnt[i] += int'(src_ready[i]);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_write", r), 32'(ram_write), 32'(vt[r].wr));
      if (vt[r].wr) begin
        chk($sformatf("vec%0d_addr", r), 32'(ram_address), 32'(vt[r].addr));
        chk($sformatf("vec%0d_data", r), 32'(ram_writedata), 32'(vt[r].wd));
      end
      chk($sformatf("vec%0d_ptr", r), 32'(wr_ptr), 32'(vt[r].ptr));
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) chk($sformatf("rr_ready_count_src%0d", i), 32'(rcnt[i]), 32'd2);
  endtask

  task automatic wrap_freeze_clear();
    int bad;
    int busy_cnt;
    int wr_cnt;
    int exp_q[$];
    do_reset();
    enable = 1'b1;
    src_valid = 4'b0001;
    src_data[15:0] = 16'h1234;
    repeat (DEPTH) @(posedge clk);
    #1;
    chk("wrap_pre_ptr",     32'(wr_ptr), 32'(DEPTH - 1));
    chk("wrap_pre_wrapped", 32'(wrapped), 32'h0);
    @(negedge clk);
    src_data[15:0] = 16'h5A5A;
    @(posedge clk); #1;
    chk("wrap_addr",    32'(ram_address), 32'(DEPTH - 1));
    chk("wrap_data",    32'(ram_writedata), 32'h5A5A);
    chk("wrap_ptr",     32'(wr_ptr), 32'h0);
    chk("wrap_wrapped", 32'(wrapped), 32'h1);
    @(negedge clk);
    src_valid = '0;
    freeze = 1'b1;
    @(posedge clk); #1;
    chk("wrap_sticky", 32'(wrapped), 32'h1);
    @(negedge clk);
    src_valid = 4'b1111;
    #1;
    chk("frz_ready", 32'(src_ready), 32'hF);
    bad = 0;
    for (int c = 1; c <= DEPTH + 1; c++) begin
      @(posedge clk); #1;
      if (ram_write) bad++;
      if (c == 10)    chk("frz_drop40", 32'(drop_count), 32'd40);
      if (c == 16383) chk("frz_drop_pre_sat", 32'(drop_count), 32'd65532);
      if (c == 16384) chk("frz_drop_sat", 32'(drop_count), 32'hFFFF);
      @(negedge clk);
    end
    chk("frz_drop_hold", 32'(drop_count), 32'hFFFF);
    chk("frz_no_write", 32'(bad), 32'd0);
    src_valid = '0;
    freeze = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    chk("clr_busy_start", 32'(busy), 32'h1);
    for (int a = 0; a < 6; a++) exp_q.push_back(a);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(a);
    busy_cnt = 1; wr_cnt = 0; bad = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      clear = (k == 5);
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (ram_write) begin
        wr_cnt++;
        if (exp_q.size() == 0) bad++;
        else if (32'(ram_address) != 32'(exp_q.pop_front()) || ram_writedata != '0) bad++;
      end
      if (!busy) break;
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'(DEPTH + 6));
    chk("clr_write_count", 32'(wr_cnt), 32'(DEPTH + 6));
    chk("clr_addr_data",   32'(bad), 32'd0);
    chk("clr_ptr",         32'(wr_ptr), 32'h0);
    chk("clr_wrapped",     32'(wrapped), 32'h0);
    chk("clr_drop",        32'(drop_count), 32'h0);
    @(negedge clk);
    clear = 1'b0;
    src_valid = 4'b0010;
    #1;
    chk("clr_then_run", 32'(src_ready), 32'h2);
    @(negedge clk);
    src_valid = '0;
  endtask

  function automatic logic [N-1:0] model_ready(input int mode, input int lg, input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    if (mode == 2) r = v;
    else if (mode == 1) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (lg + k) % N;
        if (r == '0 && v[i]) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic random_test();
    int m_mode, m_ptr, m_lg, m_drop, g, ea;
    logic [N-1:0] er;
    logic ew;
    logic [DATA_W-1:0] ed;
    do_reset();
    m_mode = 0; m_ptr = 0; m_lg = N - 1; m_drop = 0; g = 0; ea = 0; ed = '0;
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      freeze    = ($urandom_range(0, 15) == 0);
      src_valid = N'($urandom);
      src_data  = {$urandom, $urandom};
      #1;
      er = model_ready(m_mode, m_lg, src_valid);
      chk("rand_ready", 32'(src_ready), 32'(er));
      ew = 1'b0;
      if (m_mode == 1 && er != '0) begin
        for (int i = 0; i < N; i++) if (er[i]) g = i;
        ew = 1'b1;
        ea = m_ptr;
        ed = src_data[g*DATA_W +: DATA_W];
        m_ptr = (m_ptr + 1) % DEPTH;
        m_lg = g;
      end
      if (m_mode == 2) begin
        m_drop += $countones(src_valid);
        if (m_drop > 65535) m_drop = 65535;
      end
      case (m_mode)
        0: if (freeze) m_mode = 2; else if (enable) m_mode = 1;
        1: if (freeze) m_mode = 2; else if (!enable) m_mode = 0;
        default: if (!freeze) m_mode = enable ? 1 : 0;
      endcase
      @(posedge clk); #1;
      chk("rand_write", 32'({ram_chipselect, ram_write}), 32'({ew, ew}));
      if (ew) begin
        chk("rand_addr", 32'(ram_address), 32'(ea));
        chk("rand_data", 32'(ram_writedata), 32'(ed));
      end
      chk("rand_ptr",  32'(wr_ptr), 32'(m_ptr));
      chk("rand_drop", 32'(drop_count), 32'(m_drop));
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    do_reset();
`ifdef LOG_TIMESTAMP_EN
    ts_test();
`else
    hand_a5();
    table_test();
    wrap_freeze_clear();
    random_test();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
